// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA AXI write drain path.
package dma_pkg;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_AW   = 2'd1,
        WR_W    = 2'd2,
        WR_B    = 2'd3
    } wr_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int unsigned PAGE_SIZE = 4096;

    // True when a burst starting at page offset 'offset' runs past the 4KB page end.
    function automatic logic crosses_4k(input logic [11:0] offset,
                                        input logic [7:0]  len,
                                        input int unsigned bytes_per_beat);
        return (32'(offset) + (32'(len) + 32'd1) * bytes_per_beat) > PAGE_SIZE;
    endfunction

endpackage

// File: rtl/dma_axi_wr.sv
// DMA write drain: one descriptor -> one AXI4 INCR burst (AW, W, B), popping the FIFO per W beat.
// Optional build macro DMA_WR_4K_CHECK_EN rejects descriptors that cross a 4KB page.
module dma_axi_wr
    import dma_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          ID_WIDTH   = 4,
    parameter int unsigned AXI_ID     = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    desc_valid_i,
    output logic                    desc_ready_o,
    input  logic [ADDR_WIDTH-1:0]   desc_addr_i,
    input  logic [7:0]              desc_len_i,
    input  logic                    fifo_empty_i,
    input  logic [DATA_WIDTH-1:0]   fifo_data_i,
    output logic                    fifo_read_o,
    output logic [ID_WIDTH-1:0]     aw_id_o,
    output logic [ADDR_WIDTH-1:0]   aw_addr_o,
    output logic [7:0]              aw_len_o,
    output logic [2:0]              aw_size_o,
    output logic [1:0]              aw_burst_o,
    output logic                    aw_valid_o,
    input  logic                    aw_ready_i,
    output logic [DATA_WIDTH-1:0]   w_data_o,
    output logic [DATA_WIDTH/8-1:0] w_strb_o,
    output logic                    w_last_o,
    output logic                    w_valid_o,
    input  logic                    w_ready_i,
    input  logic [1:0]              b_resp_i,
    input  logic                    b_valid_i,
    output logic                    b_ready_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int unsigned BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam logic [2:0]  AXSIZE         = 3'($clog2(BYTES_PER_BEAT));

    wr_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [7:0]            len_q,   len_d;
    logic [7:0]            beat_q,  beat_d;
`ifdef DMA_WR_4K_CHECK_EN
    logic                  xerr_q,  xerr_d;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= WR_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
`ifdef DMA_WR_4K_CHECK_EN
            xerr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
`ifdef DMA_WR_4K_CHECK_EN
            xerr_q  <= xerr_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        beat_d       = beat_q;
        desc_ready_o = 1'b0;
        aw_valid_o   = 1'b0;
        w_valid_o    = 1'b0;
        w_last_o     = 1'b0;
        fifo_read_o  = 1'b0;
        b_ready_o    = 1'b0;
        done_o       = 1'b0;
        err_o        = 1'b0;
`ifdef DMA_WR_4K_CHECK_EN
        xerr_d       = 1'b0;
        // A rejected descriptor reports done+err one cycle after acceptance.
        done_o       = xerr_q;
        err_o        = xerr_q;
`endif

        unique case (state_q)
            WR_IDLE: begin
                // Held low while reset is asserted even though the state already reads IDLE.
                desc_ready_o = rstn;
                if (desc_valid_i) begin
                    addr_d = desc_addr_i;
                    len_d  = desc_len_i;
`ifdef DMA_WR_4K_CHECK_EN
                    if (crosses_4k(desc_addr_i[11:0], desc_len_i, BYTES_PER_BEAT)) begin
                        xerr_d = 1'b1;
                    end else begin
                        state_d = WR_AW;
                    end
`else
                    state_d = WR_AW;
`endif
                end
            end
            WR_AW: begin
                aw_valid_o = 1'b1;
                if (aw_ready_i) begin
                    state_d = WR_W;
                    beat_d  = '0;
                end
            end
            WR_W: begin
                w_valid_o   = ~fifo_empty_i;
                w_last_o    = w_valid_o && (beat_q == len_q);
                fifo_read_o = w_valid_o && w_ready_i;
                if (fifo_read_o) begin
                    beat_d = beat_q + 8'd1;
                    if (w_last_o) begin
                        state_d = WR_B;
                    end
                end
            end
            WR_B: begin
                b_ready_o = 1'b1;
                if (b_valid_i) begin
                    done_o  = 1'b1;
                    err_o   = (b_resp_i == AXI_RESP_SLVERR) || (b_resp_i == AXI_RESP_DECERR);
                    state_d = WR_IDLE;
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

    assign aw_id_o    = ID_WIDTH'(AXI_ID);
    assign aw_addr_o  = addr_q;
    assign aw_len_o   = len_q;
    assign aw_size_o  = AXSIZE;
    assign aw_burst_o = AXI_BURST_INCR;
    assign w_data_o   = fifo_data_i;
    assign w_strb_o   = '1;

endmodule

// File: doc/dma_axi_wr.md
Name: dma_axi_wr

Overview:
- Drain side of the DMA data FIFO. Takes one write descriptor (address, length), issues a single AXI4 INCR write burst (AW, then W, then B), and pops the `dma_fifo` one word per accepted W beat.
- Sits between `dma_fifo` (read port) and the DMA master AXI write channels.
- Reports completion and error to the DMA channel controller.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI/FIFO data width; a power of 2, at least 8.
- ID_WIDTH, 4, AXI ID width.
- AXI_ID, 0, constant AWID driven on every burst.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- desc_valid_i  input  1  descriptor offered
- desc_ready_o  output  1  descriptor accepted when high with desc_valid_i
- desc_addr_i  input  ADDR_WIDTH  burst start byte address, aligned to DATA_WIDTH/8
- desc_len_i  input  8  beats minus 1 (0 means 1 beat, 255 means 256 beats)
- fifo_empty_i  input  1  from dma_fifo empty_o
- fifo_data_i  input  DATA_WIDTH  from dma_fifo data_o (head word, combinational)
- fifo_read_o  output  1  to dma_fifo read_i
- aw_id_o  output  ID_WIDTH  AWID
- aw_addr_o  output  ADDR_WIDTH  AWADDR
- aw_len_o  output  8  AWLEN
- aw_size_o  output  3  AWSIZE
- aw_burst_o  output  2  AWBURST
- aw_valid_o  output  1  AWVALID
- aw_ready_i  input  1  AWREADY
- w_data_o  output  DATA_WIDTH  WDATA
- w_strb_o  output  DATA_WIDTH/8  WSTRB
- w_last_o  output  1  WLAST
- w_valid_o  output  1  WVALID
- w_ready_i  input  1  WREADY
- b_resp_i  input  2  BRESP
- b_valid_i  input  1  BVALID
- b_ready_o  output  1  BREADY
- done_o  output  1  one-cycle pulse: burst finished
- err_o  output  1  one-cycle pulse with done_o: error on this burst

Behaviour:
- Reset (asynchronous, rstn low):
  - State goes to IDLE; beat counter and latched address/length clear to 0.
  - All valid/ready/pulse outputs go low. desc_ready_o goes high once rstn is released.
  - Reset mid-burst abandons the burst with no completion pulse.
- Static outputs:
  - aw_id_o = AXI_ID.
  - aw_size_o = $clog2(DATA_WIDTH/8).
  - aw_burst_o = INCR (2'b01).
  - w_strb_o = all ones.
- IDLE:
  - desc_ready_o=1.
  - On desc_valid_i: latch addr and len into registers and go to AW. aw_valid_o rises the following cycle.
- AW:
  - aw_valid_o=1; aw_addr_o and aw_len_o come from the latch and are held stable until aw_ready_i.
  - On aw_ready_i: go to W and clear the beat counter.
  - No W beat is driven before the AW handshake.
- W:
  - w_valid_o = ~fifo_empty_i. w_data_o = fifo_data_i (first-word-fall-through).
  - fifo_read_o = w_valid_o & w_ready_i, so exactly one pop per accepted beat. No pop when empty; WVALID stays low meanwhile.
  - w_last_o = w_valid_o & (beat counter == latched len).
  - Beat counter is 8 bits wide and increments on each handshake. On the handshake with w_last_o high, go to B.
- B:
  - b_ready_o=1.
  - On b_valid_i: pulse done_o for one cycle, pulse err_o if b_resp_i[1]==1 (SLVERR/DECERR), and return to IDLE.
  - A new descriptor can be accepted the cycle after done_o.
- Latency, ideal slave and non-empty FIFO: descriptor accept to aw_valid_o is 1 cycle; a burst of N beats completes in N+3 cycles plus B latency.
- Boundaries:
  - len=0: a single beat with w_last_o high.
  - len=255: the counter reaches 255 without wrapping before last.
  - Address 4KB crossing is the requester's responsibility unless the optional feature is enabled.
  - desc_valid_i outside IDLE is ignored; desc_ready_o stays low.

Optional Feature:
- Macro: DMA_WR_4K_CHECK_EN.
- Defined:
  - In IDLE, a descriptor is checked for a 4KB crossing: addr[11:0] + (len+1)*DATA_WIDTH/8 > 4096.
  - A crossing descriptor is accepted but produces no AW/W activity and no FIFO pop; done_o and err_o pulse together on the next cycle.
- Undefined: the check is absent and every descriptor issues a burst.

Decomposition:
- dma_pkg holds:
  - the wr_state_t enum (IDLE, AW, W, B);
  - the AXI_BURST_INCR and AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants;
  - the 4KB page-size constant.
- No sub-module: the beat counter and FSM are inline; dma_fifo stays the upstream instance.

Test Plan:
- addr=0x1000, len=3, FIFO preloaded with A0..A3, aw/w ready held high -> AW 0x1000/len 3; four W beats A0..A3 with last on A3; 4 pops; OKAY -> done_o only.
- len=3, FIFO empty then 1 word per 3 cycles, w_ready toggling -> w_valid low while empty, no extra pops, order kept, last on the 4th beat.
- aw_ready held low for 5 cycles -> aw_addr/len stable, no W beat, then normal burst.
- len=0, BRESP=SLVERR -> single beat with last; done_o and err_o pulse together.
- rstn low during 3rd beat of len=7 -> all outputs 0 immediately, IDLE after release, no done_o; next descriptor runs cleanly.
- DMA_WR_4K_CHECK_EN, addr=0x0FF8, len=3, 32-bit -> no aw_valid, no pops, done_o+err_o next cycle; addr=0x0FF0, len=3 -> normal burst.
